// File: rtl/adda_pkg.sv
// Shared definitions for the ADC decimation and DAC interpolation paths:
// controller state encoding and accumulator sizing helpers.
package adda_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ACCUM = 2'd2
    } adda_state_e;

    // Boxcar accumulator width: sample width plus log2 of the block length.
    function automatic int acc_width(input int datawidth, input int sample_rate);
        return datawidth + sample_rate;
    endfunction

    // Half-LSB rounding term applied before the final right shift.
    function automatic int round_term(input int sample_rate);
        return (sample_rate == 0) ? 0 : (1 << (sample_rate - 1));
    endfunction

endpackage

// File: rtl/boxcar_accum.sv
// Boxcar accumulator: sums 2^SAMPLE_RATE valid samples, then emits the
// rounded average as a one-cycle done pulse with a registered result.
module boxcar_accum
    import adda_pkg::*;
#(
    parameter int SAMPLE_RATE = 4,
    parameter int DATAWIDTH   = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 add_i,
    input  logic [DATAWIDTH-1:0] sample_i,
    output logic                 done_o,
    output logic [DATAWIDTH-1:0] result_o
);

    localparam int ACC_W = acc_width(DATAWIDTH, SAMPLE_RATE);
    localparam int CNT_W = (SAMPLE_RATE == 0) ? 1 : SAMPLE_RATE;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << SAMPLE_RATE) - 1);
    localparam logic [ACC_W-1:0] RND      = ACC_W'(round_term(SAMPLE_RATE));

    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [DATAWIDTH-1:0] result_q, result_d;
    logic [ACC_W-1:0]     total_s;
    logic [ACC_W-1:0]     rounded_s;

    // Headroom of ACC_W covers the full block sum plus the rounding term.
    assign total_s   = acc_q + ACC_W'(sample_i);
    assign rounded_s = total_s + RND;

    // Next-state: discard on clear, otherwise accumulate or close the block.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add_i) begin
            if (cnt_q == CNT_LAST) begin
                acc_d    = '0;
                cnt_d    = '0;
                done_d   = 1'b1;
                result_d = DATAWIDTH'(rounded_s >> SAMPLE_RATE);
            end else begin
                acc_d = total_s;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: rtl/adc_decimator.sv
// ADC decimator: input register stage, enable FSM, boxcar averaging and
// FIFO write strobe with saturating drop accounting on back-pressure.
module adc_decimator
    import adda_pkg::*;
#(
    parameter int SAMPLE_RATE = 4,
    parameter int DATAWIDTH   = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [DATAWIDTH-1:0] adc_data_in,
    input  logic                 adc_valid_in,
    input  logic                 fifo_full,
    output logic                 wr_en,
    output logic [DATAWIDTH-1:0] wr_data,
    output logic [15:0]          drop_cnt,
    output logic                 drop_flag
);

    adda_state_e          state_q, state_d;
    logic [DATAWIDTH-1:0] s1_data_q;
    logic                 s1_valid_q;
    logic                 wr_en_q, wr_en_d;
    logic [DATAWIDTH-1:0] wr_data_q, wr_data_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;
    logic                 drop_flag_q, drop_flag_d;
    logic                 accum_on_s;
    logic                 add_s;
    logic                 done_s;
    logic [DATAWIDTH-1:0] result_s;

    // Dropping ena in ACCUM discards the partial block, even on its last sample.
    assign accum_on_s = (state_q == ST_ACCUM) && ena;
    assign add_s      = accum_on_s && s1_valid_q;

    boxcar_accum #(
        .SAMPLE_RATE (SAMPLE_RATE),
        .DATAWIDTH   (DATAWIDTH)
    ) u_boxcar (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (!accum_on_s),
        .add_i    (add_s),
        .sample_i (s1_data_q),
        .done_o   (done_s),
        .result_o (result_s)
    );

    // Controller next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ena ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: state_d = ST_ACCUM;
            ST_ACCUM: state_d = ena ? ST_ACCUM : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FIFO write or drop decision for a completed block.
    always_comb begin
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        drop_cnt_d  = drop_cnt_q;
        drop_flag_d = drop_flag_q;
        if (done_s && !fifo_full) begin
            wr_en_d   = 1'b1;
            wr_data_d = result_s;
        end else if (done_s) begin
            drop_flag_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // State, input stage and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s1_data_q   <= '0;
            s1_valid_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            drop_cnt_q  <= '0;
            drop_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_data_q   <= adc_data_in;
            s1_valid_q  <= adc_valid_in;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            drop_cnt_q  <= drop_cnt_d;
            drop_flag_q <= drop_flag_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign drop_cnt  = drop_cnt_q;
    assign drop_flag = drop_flag_q;

endmodule

// File: tb/tb_adc_decimator.sv
// Directed self-checking bench for adc_decimator (SAMPLE_RATE=4 main
// instance plus a SAMPLE_RATE=0 pass-through instance on shared inputs).
module tb_adc_decimator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [13:0] adc_data_in = 14'd0;
    logic        adc_valid_in = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_full0 = 1'b0;
    logic        wr_en, wr_en0;
    logic [13:0] wr_data, wr_data0;
    logic [15:0] drop_cnt, drop_cnt0;
    logic        drop_flag, drop_flag0;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    logic [13:0] last_data = 14'd0;
    logic [13:0] q0[$];

    adc_decimator #(.SAMPLE_RATE(4), .DATAWIDTH(14)) dut (
        .clk(clk), .rst(rst), .ena(ena), .adc_data_in(adc_data_in),
        .adc_valid_in(adc_valid_in), .fifo_full(fifo_full), .wr_en(wr_en),
        .wr_data(wr_data), .drop_cnt(drop_cnt), .drop_flag(drop_flag)
    );

    adc_decimator #(.SAMPLE_RATE(0), .DATAWIDTH(14)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .adc_data_in(adc_data_in),
        .adc_valid_in(adc_valid_in), .fifo_full(fifo_full0), .wr_en(wr_en0),
        .wr_data(wr_data0), .drop_cnt(drop_cnt0), .drop_flag(drop_flag0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            last_data = wr_data;
        end
        if (wr_en0) q0.push_back(wr_data0);
    end

    task automatic drive(input logic [13:0] d, input logic v);
        @(negedge clk);
        adc_data_in  = d;
        adc_valid_in = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(14'd0, 1'b0);
    endtask

    task automatic start_enable();
        @(negedge clk);
        ena = 1'b1;
        adc_valid_in = 1'b0;
        idle(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        tests++;
        if (wr_en !== 1'b0 || wr_data !== 14'd0 || drop_cnt !== 16'd0 || drop_flag !== 1'b0) begin
            fails++;
            $display("FAIL reset: wr_en=%b wr_data=%0d drop_cnt=%0d drop_flag=%b, want all 0",
                     wr_en, wr_data, drop_cnt, drop_flag);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        start_enable();
        wr_cnt = 0;
        for (int i = 0; i < 16; i++) drive(14'd100, 1'b1);
        drive(14'd0, 1'b0);
        tests++;
        if (wr_en !== 1'b0) begin fails++; $display("FAIL basic_lat0: wr_en=%b want 0", wr_en); end
        drive(14'd0, 1'b0);
        tests++;
        if (wr_en !== 1'b0) begin fails++; $display("FAIL basic_lat1: wr_en=%b want 0", wr_en); end
        drive(14'd0, 1'b0);
        tests++;
        if (wr_en !== 1'b1 || wr_data !== 14'd100) begin
            fails++;
            $display("FAIL basic_lat2: wr_en=%b wr_data=%0d want 1/100", wr_en, wr_data);
        end
        drive(14'd0, 1'b0);
        tests++;
        if (wr_en !== 1'b0 || wr_data !== 14'd100) begin
            fails++;
            $display("FAIL basic_hold: wr_en=%b wr_data=%0d want 0/100", wr_en, wr_data);
        end
        idle(3);
        tests++;
        if (wr_cnt !== 1) begin fails++; $display("FAIL basic_count: writes=%0d want 1", wr_cnt); end
    endtask

    task automatic test_ramp_and_fullscale();
        wr_cnt = 0;
        for (int i = 0; i < 16; i++) drive(14'(i), 1'b1);
        idle(5);
        tests++;
        if (wr_cnt !== 1 || last_data !== 14'd8) begin
            fails++;
            $display("FAIL ramp: writes=%0d data=%0d want 1/8", wr_cnt, last_data);
        end
        wr_cnt = 0;
        for (int i = 0; i < 16; i++) drive(14'd16383, 1'b1);
        idle(5);
        tests++;
        if (wr_cnt !== 1 || last_data !== 14'd16383) begin
            fails++;
            $display("FAIL fullscale: writes=%0d data=%0d want 1/16383", wr_cnt, last_data);
        end
    endtask

    task automatic test_gappy_ramp();
        wr_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            drive(14'(i), 1'b1);
            if (i < 15) drive(14'd9999, 1'b0);
        end
        drive(14'd0, 1'b0);
        drive(14'd0, 1'b0);
        tests++;
        if (wr_en !== 1'b0 || wr_cnt !== 0) begin
            fails++;
            $display("FAIL gappy_early: wr_en=%b writes=%0d want 0/0", wr_en, wr_cnt);
        end
        drive(14'd0, 1'b0);
        tests++;
        if (wr_en !== 1'b1 || wr_data !== 14'd8) begin
            fails++;
            $display("FAIL gappy_pulse: wr_en=%b wr_data=%0d want 1/8", wr_en, wr_data);
        end
        idle(3);
    endtask

    task automatic test_ena_drop();
        wr_cnt = 0;
        for (int i = 0; i < 7; i++) drive(14'd1000, 1'b1);
        @(negedge clk);
        ena = 1'b0;
        adc_valid_in = 1'b0;
        idle(3);
        start_enable();
        for (int i = 0; i < 16; i++) drive(14'd50, 1'b1);
        idle(5);
        tests++;
        if (wr_cnt !== 1 || last_data !== 14'd50) begin
            fails++;
            $display("FAIL ena_drop: writes=%0d data=%0d want 1/50", wr_cnt, last_data);
        end
    endtask

    task automatic test_ena_coincide();
        wr_cnt = 0;
        for (int i = 0; i < 15; i++) drive(14'd300, 1'b1);
        @(negedge clk);
        adc_data_in  = 14'd300;
        adc_valid_in = 1'b1;
        ena = 1'b0;
        idle(6);
        tests++;
        if (wr_cnt !== 0 || wr_data !== 14'd50) begin
            fails++;
            $display("FAIL ena_coincide: writes=%0d wr_data=%0d want 0/50", wr_cnt, wr_data);
        end
    endtask

    task automatic test_fifo_full_drop();
        start_enable();
        wr_cnt = 0;
        fifo_full = 1'b1;
        for (int i = 0; i < 32; i++) drive(14'd77, 1'b1);
        idle(5);
        tests++;
        if (wr_cnt !== 0 || drop_cnt !== 16'd2 || drop_flag !== 1'b1) begin
            fails++;
            $display("FAIL drop: writes=%0d drop_cnt=%0d drop_flag=%b want 0/2/1",
                     wr_cnt, drop_cnt, drop_flag);
        end
        fifo_full = 1'b0;
        idle(4);
        tests++;
        if (drop_flag !== 1'b1 || drop_cnt !== 16'd2) begin
            fails++;
            $display("FAIL drop_sticky: drop_flag=%b drop_cnt=%0d want 1/2", drop_flag, drop_cnt);
        end
    endtask

    task automatic test_passthrough();
        q0.delete();
        drive(14'd7, 1'b1);
        drive(14'd0, 1'b0);
        tests++;
        if (wr_en0 !== 1'b0) begin fails++; $display("FAIL pass_lat0: wr_en=%b want 0", wr_en0); end
        drive(14'd0, 1'b0);
        tests++;
        if (wr_en0 !== 1'b0) begin fails++; $display("FAIL pass_lat1: wr_en=%b want 0", wr_en0); end
        drive(14'd0, 1'b0);
        tests++;
        if (wr_en0 !== 1'b1 || wr_data0 !== 14'd7) begin
            fails++;
            $display("FAIL pass_lat2: wr_en=%b wr_data=%0d want 1/7", wr_en0, wr_data0);
        end
        drive(14'd9, 1'b1);
        drive(14'd11, 1'b1);
        drive(14'd13, 1'b1);
        idle(5);
        tests++;
        if (q0.size() != 4) begin
            fails++;
            $display("FAIL pass_count: writes=%0d want 4", q0.size());
        end else if (q0[0] !== 14'd7 || q0[1] !== 14'd9 || q0[2] !== 14'd11 || q0[3] !== 14'd13) begin
            fails++;
            $display("FAIL pass_data: got %0d %0d %0d %0d want 7 9 11 13", q0[0], q0[1], q0[2], q0[3]);
        end
    endtask

    task automatic test_rst_mid_block();
        for (int i = 0; i < 10; i++) drive(14'd200, 1'b1);
        @(negedge clk);
        adc_valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (wr_en !== 1'b0 || wr_data !== 14'd0 || drop_cnt !== 16'd0 || drop_flag !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: wr_en=%b wr_data=%0d drop_cnt=%0d drop_flag=%b want all 0",
                     wr_en, wr_data, drop_cnt, drop_flag);
        end
        rst = 1'b0;
        wr_cnt = 0;
        start_enable();
        for (int i = 0; i < 16; i++) drive(14'd200, 1'b1);
        idle(5);
        tests++;
        if (wr_cnt !== 1 || last_data !== 14'd200) begin
            fails++;
            $display("FAIL rst_recover: writes=%0d data=%0d want 1/200", wr_cnt, last_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ramp_and_fullscale();
        test_gappy_ramp();
        test_ena_drop();
        test_ena_coincide();
        test_fifo_full_drop();
        test_passthrough();
        test_rst_mid_block();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
